prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Parametrised successor to the 8-bit up/down counter used behind the custom AXI counter IP.
- Generalised in count width, with a programmable tick prescaler, an upper limit, three terminal-count modes (wrap, auto-reload, one-shot) and an explicit synchronous load.
- Sits behind the AXI-Lite register slave: all control inputs come from slave registers, and all outputs are read back or routed to the interrupt line.

Parameters:
- WIDTH, 16, counter width in bits (2..32).
- PRESCALE_W, 8, prescaler register width in bits.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  run/pause level.
- inc_dec  in  1  direction: 0 = up, 1 = down.
- mode  in  2  terminal mode: 00 WRAP, 01 RELOAD, 10 ONESHOT, 11 = WRAP.
- load  in  1  single-cycle pulse; loads load_value.
- load_value  in  WIDTH  load / reload value.
- limit  in  WIDTH  terminal value when counting up.
- prescale  in  PRESCALE_W  tick divider; one tick every prescale+1 cycles.
- count_out  out  WIDTH  current count.
- tc_pulse  out  1  single-cycle terminal-count strobe.
- done  out  1  one-shot finished (sticky).
- running  out  1  FSM is in RUN.

Behaviour:
- Reset: aresetn is asynchronous, active-low; clock is aclk. On reset: count_out=0, reload_reg=0, prescale_cnt=0, tc_pulse=0, done=0, running=0, state=IDLE.
- All outputs are registered. count_out changes on the edge after a qualifying tick or load.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0 (pause). count_out and prescale_cnt are held.
  - RUN -> DONE on the terminal tick in ONESHOT mode.
  - DONE -> IDLE only on load. enable is ignored in DONE.
- Prescaler (RUN only):
  - tick = (prescale_cnt == prescale).
  - On tick, prescale_cnt clears to 0; otherwise it increments.
  - prescale=0 gives a tick every cycle.
  - A new prescale value takes effect on the next compare.
- Terminal condition, evaluated on a tick:
  - Up: count_out >= limit. Using >= covers a value loaded above limit.
  - Down: count_out == 0.
- Non-terminal tick: count_out ±1, modulo 2^WIDTH.
- Terminal tick: tc_pulse=1 for exactly one cycle, then by mode:
  - WRAP: up -> 0; down -> limit.
  - RELOAD: count_out <= reload_reg (either direction).
  - ONESHOT: count_out holds, done<=1, state -> DONE.
- load (any state):
  - count_out <= load_value; reload_reg <= load_value; prescale_cnt <= 0; done <= 0.
  - DONE -> IDLE; RUN stays RUN.
  - No tick is processed that cycle and no tc_pulse is generated. load has priority over a simultaneous tick.
- Changes to mode or inc_dec are sampled every cycle and apply from the next tick.
- limit=0 with up count: every tick is terminal.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro PROG_COUNTER_CMP_EN.
- When defined:
  - Adds input cmp_value [WIDTH] and output cmp_match [1].
  - cmp_match is registered: it is 1 in the cycle after count_out == cmp_value while in RUN or DONE, and 0 in IDLE.
  - cmp_match resets to 0.
- When undefined: neither port exists, and there is no comparator logic.

Test Plan:
- WRAP up: load 0, limit=3, prescale=0, enable=1 -> count_out 0,1,2,3,0,1 on consecutive cycles; tc_pulse high exactly on the 3->0 edge.
- Prescaler: prescale=2, up, from 0 -> count_out advances every 3rd cycle (0,0,0,1,1,1,2); pausing with enable=0 for 5 cycles holds both count_out and prescale_cnt.
- RELOAD down: load 5, mode=01, inc_dec=1 -> 5,4,3,2,1,0,5,4; tc_pulse on the 0->5 edge; done stays 0.
- ONESHOT up: load 0, limit=2 -> 0,1,2 then held at 2; tc_pulse once; done=1, running=0. Dropping and re-raising enable has no effect. A load of 7 clears done, count_out=7, state returns to IDLE.
- Collision: load asserted in the same cycle as a terminal tick (WRAP, count_out=limit=3, load_value=9) -> count_out=9, no tc_pulse. Then with limit=3 and up counting, the next tick is terminal (9 >= 3) and wraps to 0.
- Async reset mid-count at count_out=0x00A5, PRESCALE_W=8, prescale=4 -> count_out, tc_pulse, done and running all go to 0 immediately, before the next clock edge. With PROG_COUNTER_CMP_EN defined and cmp_value=2, cmp_match pulses in the cycle after count_out=2.

Source files
------------

// File: rtl/prog_counter.sv
// Programmable up/down counter: prescaler, limit, wrap/reload/one-shot modes.
// Define PROG_COUNTER_CMP_EN to add the cmp_value/cmp_match comparator.
module prog_counter #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  inc_dec,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef PROG_COUNTER_CMP_EN
  input  logic [WIDTH-1:0]      cmp_value,
  output logic                  cmp_match,
`endif
  output logic [WIDTH-1:0]      count_out,
  output logic                  tc_pulse,
  output logic                  done,
  output logic                  running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_RELOAD  = 2'b01;
  localparam logic [1:0] M_ONESHOT = 2'b10;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  run_q;

  logic tick;
  logic term;

  assign tick = (pre_q == prescale);
  // >= so a value loaded above limit still terminates
  assign term = inc_dec ? (count_q == '0) : (count_q >= limit);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      pre_d    = '0;
      done_d   = 1'b0;
      unique case (state_q)
        DONE:    state_d = IDLE;
        IDLE:    state_d = enable ? RUN : IDLE;
        default: state_d = RUN;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (tick) begin
            pre_d = '0;
            if (term) begin
              tc_d = 1'b1;
              unique case (mode)
                M_RELOAD: count_d = reload_q;
                M_ONESHOT: begin
                  done_d  = 1'b1;
                  state_d = DONE;
                end
                default: count_d = inc_dec ? limit : '0;
              endcase
            end else begin
              count_d = inc_dec ? count_q - 1'b1 : count_q + 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
      run_q    <= (state_d == RUN);
    end
  end

  assign count_out = count_q;
  assign tc_pulse  = tc_q;
  assign done      = done_q;
  assign running   = run_q;

`ifdef PROG_COUNTER_CMP_EN
  logic cmp_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= (state_q != IDLE) && (count_q == cmp_value);
    end
  end

  assign cmp_match = cmp_q;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Directed scoreboard bench for prog_counter (WIDTH=16, PRESCALE_W=8).
module tb_prog_counter;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic        inc_dec;
  logic [1:0]  mode;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] limit;
  logic [7:0]  prescale;
  logic [15:0] count_out;
  logic        tc_pulse;
  logic        done;
  logic        running;
`ifdef PROG_COUNTER_CMP_EN
  logic [15:0] cmp_value;
  logic        cmp_match;
`endif

  int n_cmp;
  int n_err;

  typedef struct {
    logic [15:0] c;
    logic        tc;
    logic        dn;
    logic        run;
  } exp_t;

  exp_t sb[$];

  prog_counter #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .inc_dec    (inc_dec),
    .mode       (mode),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .prescale   (prescale),
`ifdef PROG_COUNTER_CMP_EN
    .cmp_value  (cmp_value),
    .cmp_match  (cmp_match),
`endif
    .count_out  (count_out),
    .tc_pulse   (tc_pulse),
    .done       (done),
    .running    (running)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] c, input logic tc,
                     input logic dn, input logic run);
    exp_t e;
    sb.push_back('{c: c, tc: tc, dn: dn, run: run});
    @(posedge aclk);
    #1;
    e = sb.pop_front();
    chk("count", 32'(count_out), 32'(e.c));
    chk("tc", 32'(tc_pulse), 32'(e.tc));
    chk("done", 32'(done), 32'(e.dn));
    chk("running", 32'(running), 32'(e.run));
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    aresetn    = 1'b0;
    enable     = 1'b0;
    inc_dec    = 1'b0;
    mode       = 2'b00;
    load       = 1'b0;
    load_value = '0;
    limit      = 16'd3;
    prescale   = 8'd0;
`ifdef PROG_COUNTER_CMP_EN
    cmp_value  = 16'd2;
`endif
    #12;
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_tc", 32'(tc_pulse), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // WRAP up, limit 3
    load = 1'b1; load_value = 16'd0;
    cyc(16'd0, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    cyc(16'd0, 0, 0, 1);
    cyc(16'd1, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    cyc(16'd3, 0, 0, 1);
    cyc(16'd0, 1, 0, 1);
    cyc(16'd1, 0, 0, 1);

    // prescaler 2 and pause
    load = 1'b1; load_value = 16'd0; prescale = 8'd2; limit = 16'd100;
    cyc(16'd0, 0, 0, 1);
    load = 1'b0;
    cyc(16'd0, 0, 0, 1);
    cyc(16'd0, 0, 0, 1);
    cyc(16'd1, 0, 0, 1);
    cyc(16'd1, 0, 0, 1);
    cyc(16'd1, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cyc(16'd2, 0, 0, 0);
    enable = 1'b1;
    cyc(16'd2, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    cyc(16'd3, 0, 0, 1);

    // RELOAD down from 5
    prescale = 8'd0; mode = 2'b01; inc_dec = 1'b1;
    load = 1'b1; load_value = 16'd5;
    cyc(16'd5, 0, 0, 1);
    load = 1'b0;
    cyc(16'd4, 0, 0, 1);
    cyc(16'd3, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    cyc(16'd1, 0, 0, 1);
    cyc(16'd0, 0, 0, 1);
    cyc(16'd5, 1, 0, 1);
    cyc(16'd4, 0, 0, 1);

    // ONESHOT up, limit 2
    mode = 2'b10; inc_dec = 1'b0; limit = 16'd2;
    load = 1'b1; load_value = 16'd0;
    cyc(16'd0, 0, 0, 1);
    load = 1'b0;
    cyc(16'd1, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    cyc(16'd2, 1, 1, 0);
    cyc(16'd2, 0, 1, 0);
    enable = 1'b0;
    cyc(16'd2, 0, 1, 0);
    enable = 1'b1;
    cyc(16'd2, 0, 1, 0);
    cyc(16'd2, 0, 1, 0);
    enable = 1'b0; load = 1'b1; load_value = 16'd7;
    cyc(16'd7, 0, 0, 0);
    load = 1'b0;
    cyc(16'd7, 0, 0, 0);

    // load colliding with a terminal tick
    mode = 2'b00; limit = 16'd3;
    load = 1'b1; load_value = 16'd3;
    cyc(16'd3, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    cyc(16'd3, 0, 0, 1);
    load = 1'b1; load_value = 16'd9;
    cyc(16'd9, 0, 0, 1);
    load = 1'b0;
    cyc(16'd0, 1, 0, 1);
    cyc(16'd1, 0, 0, 1);

    // limit 0: every tick terminal
    limit = 16'd0;
    cyc(16'd0, 1, 0, 1);
    cyc(16'd0, 1, 0, 1);

`ifdef PROG_COUNTER_CMP_EN
    limit = 16'd10; load = 1'b1; load_value = 16'd0;
    cyc(16'd0, 0, 0, 1);
    load = 1'b0;
    cyc(16'd1, 0, 0, 1);
    cyc(16'd2, 0, 0, 1);
    chk("cmp_pre", 32'(cmp_match), 32'd0);
    cyc(16'd3, 0, 0, 1);
    chk("cmp_hit", 32'(cmp_match), 32'd1);
    cyc(16'd4, 0, 0, 1);
    chk("cmp_post", 32'(cmp_match), 32'd0);
`else
    limit = 16'd10;
`endif

    // async reset mid-count at 0x00A5
    prescale = 8'd4; load = 1'b1; load_value = 16'h00A5;
    cyc(16'h00A5, 0, 0, 1);
    load = 1'b0;
    cyc(16'h00A5, 0, 0, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_count", 32'(count_out), 32'd0);
    chk("arst_tc", 32'(tc_pulse), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_run", 32'(running), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1; enable = 1'b0;
    cyc(16'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
